p_window_stats: RTL and testbench

Windowed statistics stage directly downstream of the free-running 16-bit `o_p` generator. It takes the generator's `o_p` stream on `i_p` and, over consecutive non-overlapping windows of `WIN_LEN` accepted samples, computes sum, minimum and maximum. At each window end it publishes the results with a one-cycle valid pulse. It gives the bench and later stages a compact, checkable summary of the generator output instead of a raw per-cycle waveform.

---
 rtl/p_pkg.sv | 15 +
 rtl/p_minmax.sv | 46 ++++
 rtl/p_window_stats.sv | 108 ++++++++++
 tb/tb_p_window_stats.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/p_pkg.sv
// Shared definitions for the p_* generator-output processing blocks.
//   P_DATA_W      : sample width of the generator o_p stream
//   P_WIN_LEN_DEF : default number of accepted samples per statistics window
//   state_t       : window FSM states
package p_pkg;

  localparam int unsigned P_DATA_W      = 16;
  localparam int unsigned P_WIN_LEN_DEF = 16;

  typedef enum logic {
    S_FIRST,
    S_ACC
  } state_t;

endpackage

// File: rtl/p_minmax.sv
// Registered unsigned min/max tracker.
//   clk, rst          : clock, synchronous active-high reset (state -> 0)
//   load              : start a new run; min/max both take d
//   update            : fold d into the running min/max
//   d                 : sample
//   min_q, max_q      : registered running min/max
//   min_nxt, max_nxt  : value the registers take on the coming edge
//                       (includes d when load/update is active)
module p_minmax #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] min_q,
  output logic [DATA_W-1:0] max_q,
  output logic [DATA_W-1:0] min_nxt,
  output logic [DATA_W-1:0] max_nxt
);

  always_comb begin
    min_nxt = min_q;
    max_nxt = max_q;
    if (load) begin
      min_nxt = d;
      max_nxt = d;
    end else if (update) begin
      // Strict compares: on a tie the held value is kept.
      if (d < min_q) min_nxt = d;
      if (d > max_q) max_nxt = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

endmodule

// File: rtl/p_window_stats.sv
// Windowed statistics over the generator o_p stream.
// Over consecutive non-overlapping windows of WIN_LEN accepted samples,
// computes unsigned sum, min and max, and publishes them with a one-cycle
// valid pulse on the edge that accepts the last sample of the window.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_p       : sample (unsigned), accepted when i_en=1
//   i_en      : sample accept
//   o_sum     : sum of last completed window (SUM_W bits, never overflows)
//   o_min     : minimum of last completed window
//   o_max     : maximum of last completed window
//   o_valid   : one-cycle pulse, results just updated
//   o_win_cnt : completed-window count, wraps 255 -> 0
module p_window_stats
  import p_pkg::*;
#(
  parameter  int unsigned DATA_W  = P_DATA_W,
  parameter  int unsigned WIN_LEN = P_WIN_LEN_DEF,
  localparam int unsigned SUM_W   = DATA_W + $clog2(WIN_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_p,
  input  logic              i_en,
  output logic [SUM_W-1:0]  o_sum,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic              o_valid,
  output logic [7:0]        o_win_cnt
);

  localparam int unsigned IDX_W = $clog2(WIN_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_LEN - 1);

  state_t state, state_n;

  logic [IDX_W-1:0]  idx;
  logic [SUM_W-1:0]  acc_sum;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] acc_min, acc_max;
  logic [DATA_W-1:0] min_nxt, max_nxt;
  logic              load, update, close;

  assign load    = i_en && (state == S_FIRST);
  assign update  = i_en && (state == S_ACC);
  // WIN_LEN >= 2, so only S_ACC can close a window.
  assign close   = update && (idx == IDX_LAST);
  assign sum_nxt = acc_sum + SUM_W'(i_p);

  p_minmax #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .update  (update),
    .d       (i_p),
    .min_q   (acc_min),
    .max_q   (acc_max),
    .min_nxt (min_nxt),
    .max_nxt (max_nxt)
  );

  always_comb begin
    state_n = state;
    if (load)  state_n = S_ACC;
    if (close) state_n = S_FIRST;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FIRST;
    else       state <= state_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_sum <= '0;
      idx     <= '0;
    end else if (load) begin
      acc_sum <= SUM_W'(i_p);
      idx     <= IDX_W'(1);
    end else if (update) begin
      acc_sum <= sum_nxt;
      idx     <= idx + IDX_W'(1);
    end
  end

  // Results are taken from the next-value terms so the closing sample is
  // included without an extra cycle of latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sum     <= '0;
      o_min     <= '0;
      o_max     <= '0;
      o_valid   <= 1'b0;
      o_win_cnt <= '0;
    end else begin
      o_valid <= close;
      if (close) begin
        o_sum     <= sum_nxt;
        o_min     <= min_nxt;
        o_max     <= max_nxt;
        o_win_cnt <= o_win_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_p_window_stats.sv
module tb_p_window_stats;

  localparam int unsigned WIN = 16;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_p = '0;
  logic        i_en = 1'b0;
  logic [19:0] o_sum;
  logic [15:0] o_min, o_max;
  logic        o_valid;
  logic [7:0]  o_win_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  p_window_stats #(
    .DATA_W  (16),
    .WIN_LEN (WIN)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_p       (i_p),
    .i_en      (i_en),
    .o_sum     (o_sum),
    .o_min     (o_min),
    .o_max     (o_max),
    .o_valid   (o_valid),
    .o_win_cnt (o_win_cnt)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: collect accepted samples; when a window is full,
  // compute its statistics with plain arithmetic.
  int unsigned     q[$];
  longint unsigned m_sum = 0;
  int unsigned     m_min = 0, m_max = 0;
  bit              m_valid = 0;
  bit [7:0]        m_cnt = 0;

  always @(posedge clk) begin
    if (i_rst) begin
      q.delete();
      m_sum = 0; m_min = 0; m_max = 0; m_valid = 0; m_cnt = 0;
    end else begin
      m_valid = 0;
      if (i_en) begin
        q.push_back(int'(i_p));
        if (q.size() == WIN) begin
          m_sum = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
          foreach (q[k]) begin
            m_sum += q[k];
            if (q[k] < m_min) m_min = q[k];
            if (q[k] > m_max) m_max = q[k];
          end
          m_valid = 1;
          m_cnt   = m_cnt + 8'd1;
          q.delete();
        end
      end
    end
  end

  // Every-cycle compare, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    chk("valid",   o_valid,   m_valid);
    chk("win_cnt", o_win_cnt, m_cnt);
    chk("sum",     o_sum,     m_sum);
    chk("min",     o_min,     m_min);
    chk("max",     o_max,     m_max);
  end

  task automatic put(input logic [15:0] p, input logic en);
    @(negedge clk);
    i_rst = 1'b0;
    i_p   = p;
    i_en  = en;
  endtask

  // One reset edge; the sample offered alongside must be dropped.
  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_en  = 1'b1;
    i_p   = 16'($urandom);
  endtask

  int unsigned pulses;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_cnt", o_win_cnt, 0);

    // Constant 5
    do_reset();
    for (int k = 0; k < 16; k++) put(16'd5, 1'b1);
    put(16'($urandom), 1'b0);
    chk("const_valid", o_valid, 1);
    chk("const_sum", o_sum, 80);
    chk("const_min", o_min, 5);
    chk("const_max", o_max, 5);
    chk("const_cnt", o_win_cnt, 1);
    put(16'($urandom), 1'b0);
    chk("const_pulse_end", o_valid, 0);
    chk("const_hold", o_sum, 80);

    // Ramp, back-to-back windows
    do_reset();
    for (int k = 0; k < 32; k++) begin
      put(16'(k), 1'b1);
      if (k == 16) begin
        chk("ramp1_valid", o_valid, 1);
        chk("ramp1_sum", o_sum, 120);
        chk("ramp1_min", o_min, 0);
        chk("ramp1_max", o_max, 15);
      end
    end
    put(16'd0, 1'b0);
    chk("ramp2_valid", o_valid, 1);
    chk("ramp2_sum", o_sum, 376);
    chk("ramp2_min", o_min, 16);
    chk("ramp2_max", o_max, 31);
    chk("ramp2_cnt", o_win_cnt, 2);

    // Saturating values
    do_reset();
    for (int k = 0; k < 16; k++) put(16'hFFFF, 1'b1);
    put(16'd0, 1'b0);
    chk("sat_sum", o_sum, 20'hFFFF0);
    chk("sat_min", o_min, 16'hFFFF);
    chk("sat_max", o_max, 16'hFFFF);

    // Gated ramp
    do_reset();
    for (int k = 0; k < 16; k++) begin
      put(16'(k), 1'b1);
      put(16'($urandom), 1'b0);
    end
    chk("gate_valid", o_valid, 1);
    chk("gate_sum", o_sum, 120);
    chk("gate_min", o_min, 0);
    chk("gate_max", o_max, 15);

    // Reset mid-window
    do_reset();
    for (int k = 0; k < 7; k++) put(16'd100, 1'b1);
    do_reset();
    for (int k = 0; k < 16; k++) put(16'd3, 1'b1);
    put(16'd0, 1'b0);
    chk("midrst_sum", o_sum, 48);
    chk("midrst_min", o_min, 3);
    chk("midrst_max", o_max, 3);
    chk("midrst_cnt", o_win_cnt, 1);

    // Live random generator stream, long enough to wrap the window counter
    do_reset();
    pulses = 0;
    for (int c = 0; c < 260 * 16; c++) begin
      put(16'($urandom), 1'b1);
      if (o_valid) begin
        pulses++;
        if (pulses == 256) chk("cnt_wrap", o_win_cnt, 0);
      end
    end
    put(16'd0, 1'b0);
    if (o_valid) pulses++;
    chk("live_pulses", pulses, 260);

    // Random gating with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) do_reset();
      else put(16'($urandom), 1'($urandom_range(1)));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
